kyber_bytes_to_bits: RTL and testbench

Clocked Kyber `BytesToBits` unpacker. It converts an array of up to `BYTE_COUNT` bytes into a flat little-endian bit vector: bit `j` of byte `i` becomes output bit `8*i+j`. It sits in the Kyber-768-90s datapath ahead of the sampling and decoding stages that consume individual bits. It captures its inputs on a start pulse, converts one byte per cycle, and flags completion.

---
 rtl/kyber_bytes_to_bits.sv | 100 ++++++++++
 tb/tb_kyber_bytes_to_bits.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/kyber_bytes_to_bits.sv
// Kyber BytesToBits unpacker: captures up to BYTE_COUNT bytes, places one per cycle.
// Bit j of byte i lands at b[8*i+j]; byte positions at or beyond len read as zero.
module kyber_bytes_to_bits #(
    parameter int BYTE_COUNT = 128,
    parameter int BIT_COUNT  = BYTE_COUNT * 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  B [BYTE_COUNT-1:0],
    input  logic [$clog2(BYTE_COUNT):0] len,
    output logic [BIT_COUNT-1:0]        b,
    output logic                        busy,
    output logic                        done
);
    localparam int LW = $clog2(BYTE_COUNT) + 1;
    localparam int IW = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;

    if (BIT_COUNT != BYTE_COUNT * 8) begin : g_bad_width
        $error("BIT_COUNT must equal BYTE_COUNT*8");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e               state_q, state_d;
    logic [LW-1:0]        k_q, k_d;
    logic [LW-1:0]        nlen_q, nlen_d;
    logic [LW-1:0]        len_clamped;
    logic [BIT_COUNT-1:0] b_q, b_d;
    logic [7:0]           bytes_q [BYTE_COUNT-1:0];
    logic                 accept;
    logic                 last;

    assign accept      = (state_q == IDLE) && start;
    assign len_clamped = (len > LW'(BYTE_COUNT)) ? LW'(BYTE_COUNT) : len;
    assign last        = (k_q == nlen_q - LW'(1));
    assign b           = b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            nlen_q  <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            nlen_q  <= nlen_d;
            b_q     <= b_d;
        end
    end

    // Byte buffer needs no reset: it is only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            bytes_q <= B;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_clamped != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        b_d    = b_q;
        k_d    = k_q;
        nlen_d = nlen_q;
        busy   = (state_q == BUSY);
        done   = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    b_d    = '0;
                    k_d    = '0;
                    nlen_d = len_clamped;
                end
            end
            BUSY: begin
                b_d[{k_q[IW-1:0], 3'b000} +: 8] = bytes_q[k_q[IW-1:0]];
                k_d = k_q + LW'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_kyber_bytes_to_bits.sv
// Scoreboard bench for kyber_bytes_to_bits: driver queues expected results,
// monitor checks them whenever done pulses.
module tb_kyber_bytes_to_bits;
    localparam int BC = 128;
    localparam int LW = $clog2(BC) + 1;

    typedef struct {
        logic [BC*8-1:0] b;
        int              when_n;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      B [BC-1:0];
    logic [LW-1:0]   len;
    logic [BC*8-1:0] b;
    logic            busy;
    logic            done;

    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    kyber_bytes_to_bits #(.BYTE_COUNT(BC)) dut (
        .clk(clk), .rst(rst), .start(start), .B(B),
        .len(len), .b(b), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at edge %0d, expected 0", edges);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", edges, e.when_n);
                for (int i = 0; i < BC; i++) begin
                    check($sformatf("b_byte%0d", i), b[8*i +: 8], e.b[8*i +: 8]);
                end
            end
        end
    end

    task automatic issue(input int l, input bit push);
        exp_t e;
        int   nl;
        @(negedge clk);
        nl = (l > BC) ? BC : l;
        e.b = '0;
        for (int i = 0; i < nl; i++) e.b[8*i +: 8] = B[i];
        e.when_n = edges + 1 + nl;
        if (push) q.push_back(e);
        len   = LW'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected %0d pending", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < BC; i++) B[i] = 8'($urandom);
        len   = LW'(5);
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_b", |b, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        // full length
        B[0]   = 8'h2B;
        B[1]   = 8'h19;
        B[127] = 8'hB9;
        issue(128, 1'b1);
        check("full_busy", busy, 1);
        wait_done();
        check("full_b7_0", b[7:0], 8'h2B);
        check("full_bit0", b[0], 1);
        check("full_bit1", b[1], 1);
        check("full_bit2", b[2], 0);
        check("full_bit3", b[3], 1);
        check("full_b15_8", b[15:8], 8'h19);
        check("full_btop", b[1023:1016], 8'hB9);
        check("full_idle_busy", busy, 0);

        // partial length
        for (int i = 0; i < BC; i++) B[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) B[i] = 8'hFF;
        issue(3, 1'b1);
        wait_done();
        check("part_low", b[23:0], 24'hFFFFFF);
        check("part_high_zero", |b[1023:24], 0);

        // zero length
        issue(0, 1'b1);
        check("zero_busy", busy, 0);
        wait_done();
        check("zero_b", |b, 0);

        // capture and ignore
        B[0] = 8'hA5;
        B[1] = 8'h3C;
        issue(4, 1'b1);
        B[0]  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("capt_b7_0", b[7:0], 8'hA5);
        check("capt_b15_8", b[15:8], 8'h3C);

        // over-length clamps to BYTE_COUNT
        for (int i = 0; i < BC; i++) B[i] = 8'($urandom);
        issue(200, 1'b1);
        wait_done();
        check("clamp_btop", b[1023:1016], B[127]);

        // mid-run reset
        for (int i = 0; i < BC; i++) B[i] = 8'($urandom) | 8'h01;
        issue(128, 1'b0);
        repeat (8) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_b_nonzero", |b, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_b", |b, 0);
        check("mid_rst_busy", busy, 0);
        issue(100, 1'b1);
        wait_done();
        check("after_rst_b0", b[7:0], B[0]);
        check("after_rst_hi", |b[1023:800], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
